router_ingress: RTL and testbench

Input stage of the 1x3 router, directly downstream of the source-side driver/monitor interface. It accepts byte-serial packets on `pkt_valid`/`data_in` and decodes the header (destination, payload length). It forwards every byte of the packet (header, payload, parity) to one of three output FIFOs through a one-entry hold register, and applies back-pressure on `busy` when the selected FIFO is full. It checks packet parity, reports mismatches on `error`, and silently drops packets addressed to the invalid port.

---
 rtl/router_pkg.sv | 35 +++
 rtl/router_ingress_if.sv | 26 ++
 rtl/router_hold_reg.sv | 55 +++++
 rtl/router_ingress.sv | 81 ++++++++
 tb/tb_router_ingress.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and header field layout for the router ingress stage
package router_pkg;

  localparam int DATA_W      = 8;
  localparam int NUM_PORTS   = 3;
  localparam int MAX_PAYLOAD = 63;
  localparam int CNT_W       = $clog2(MAX_PAYLOAD + 1);

  localparam int HDR_DEST_LSB = 0;
  localparam int HDR_DEST_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

  typedef enum logic [1:0] {
    PORT0    = 2'd0,
    PORT1    = 2'd1,
    PORT2    = 2'd2,
    PORT_INV = 2'd3
  } addr_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2
  } state_t;

  function automatic addr_t hdr_dest(input logic [DATA_W-1:0] hdr);
    return addr_t'(hdr[HDR_DEST_MSB:HDR_DEST_LSB]);
  endfunction

  function automatic logic [CNT_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

endpackage

// File: rtl/router_ingress_if.sv
// rtl/router_ingress_if.sv - source-side byte stream and FIFO write bus of the ingress stage
interface router_ingress_if #(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 3
);

  logic                 pkt_valid;
  logic [DATA_W-1:0]    data_in;
  logic                 busy;
  logic                 error;
  logic                 pkt_done;
  logic [NUM_PORTS-1:0] fifo_full;
  logic [NUM_PORTS-1:0] wr_en;
  logic [DATA_W-1:0]    wr_data;

  modport master (
    output pkt_valid, data_in, fifo_full,
    input  busy, error, pkt_done, wr_en, wr_data
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    output busy, error, pkt_done, wr_en, wr_data
  );

endinterface

// File: rtl/router_hold_reg.sv
// rtl/router_hold_reg.sv - one-entry destination-tagged hold register feeding the output FIFOs
module router_hold_reg
  import router_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 3
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 load,
  input  logic [DATA_W-1:0]    load_data,
  input  addr_t                load_dest,
  input  logic [NUM_PORTS-1:0] fifo_full,
  output logic                 busy,
  output logic [NUM_PORTS-1:0] wr_en,
  output logic [DATA_W-1:0]    wr_data
);

  logic [DATA_W-1:0] hold;
  addr_t             hold_dest;
  logic              hold_valid;
  logic              dest_full;
  logic              drain;

  // An invalid destination matches no port, so it never reports full and drains silently.
  always_comb begin
    dest_full = 1'b0;
    wr_en     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (int'(hold_dest) == i) begin
        dest_full = fifo_full[i];
        wr_en[i]  = hold_valid & ~fifo_full[i];
      end
    end
  end

  assign busy    = hold_valid & dest_full;
  assign drain   = hold_valid & ~dest_full;
  assign wr_data = hold;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hold       <= '0;
      hold_dest  <= PORT0;
      hold_valid <= 1'b0;
    end else if (load) begin
      hold       <= load_data;
      hold_dest  <= load_dest;
      hold_valid <= 1'b1;
    end else if (drain) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/router_ingress.sv
// rtl/router_ingress.sv - header decode, length count and parity check FSM of the 1x3 router input stage
module router_ingress
  import router_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 3
) (
  input  logic        clock,
  input  logic        resetn,
  router_ingress_if.slave bus
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] par;
  addr_t             dest;
  logic              error_r;
  logic              done_r;
  logic              hold_busy;
  logic              accept;
  addr_t             load_dest;

  assign accept    = bus.pkt_valid & ~hold_busy;
  // The header byte itself must already carry its own destination tag into the hold register.
  assign load_dest = (state == IDLE) ? hdr_dest(bus.data_in) : dest;

  assign bus.busy     = hold_busy;
  assign bus.error    = error_r;
  assign bus.pkt_done = done_r;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      par     <= '0;
      dest    <= PORT0;
      error_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        unique case (state)
          IDLE: begin
            dest    <= hdr_dest(bus.data_in);
            cnt     <= hdr_len(bus.data_in);
            par     <= bus.data_in;
            error_r <= 1'b0;
            state   <= (hdr_len(bus.data_in) == '0) ? PARITY : PAYLOAD;
          end
          PAYLOAD: begin
            par <= par ^ bus.data_in;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= PARITY;
          end
          PARITY: begin
            error_r <= (bus.data_in != par) || (dest == PORT_INV);
            done_r  <= 1'b1;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  router_hold_reg #(
    .DATA_W    (DATA_W),
    .NUM_PORTS (NUM_PORTS)
  ) u_hold (
    .clock     (clock),
    .resetn    (resetn),
    .load      (accept),
    .load_data (bus.data_in),
    .load_dest (load_dest),
    .fifo_full (bus.fifo_full),
    .busy      (hold_busy),
    .wr_en     (bus.wr_en),
    .wr_data   (bus.wr_data)
  );

endmodule

// File: tb/tb_router_ingress.sv
// tb/tb_router_ingress.sv - self-checking bench for router_ingress
module tb_router_ingress;

  typedef struct {
    int         port;
    logic [7:0] data;
    int         edge_n;
  } wr_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  router_ingress_if bus ();

  router_ingress dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  busy_cnt = 0;
  int  bad_onehot = 0;
  bit  rand_full = 1'b0;
  wr_t obs[$];
  int  acc_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.wr_en != 3'b000) begin
      wr_t w;
      if (!$onehot(bus.wr_en)) bad_onehot++;
      w.port = -1;
      for (int i = 0; i < 3; i++) if (bus.wr_en[i]) w.port = i;
      w.data   = bus.wr_data;
      w.edge_n = cyc + 1;
      obs.push_back(w);
    end
    if (bus.pkt_done === 1'b1) done_cnt++;
    if (bus.busy === 1'b1) busy_cnt++;
  end

  task automatic upd_full();
    if (rand_full) begin
      for (int i = 0; i < 3; i++) bus.fifo_full[i] = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic idle(input int n);
    bus.pkt_valid = 1'b0;
    repeat (n) begin
      @(posedge clock); #1;
      upd_full();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    bus.pkt_valid = 1'b1;
    bus.data_in   = b;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clock);
      if (bus.busy === 1'b0) begin
        acc_q.push_back(cyc + 1);
        ok = 1'b1;
      end
      @(posedge clock); #1;
      upd_full();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout byte=%h busy=%b required busy=0", b, bus.busy);
    end
  endtask

  function automatic bit model_err(input logic [7:0] p[$]);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < p.size() - 1; i++) x ^= p[i];
    return (x != p[p.size()-1]) || (p[0][1:0] == 2'd3);
  endfunction

  task automatic send_pkt(input logic [7:0] p[$], input int gap_max, input bit exp_err);
    foreach (p[i]) begin
      if (gap_max > 0) begin
        int g = $urandom_range(0, gap_max);
        if (g > 0) idle(g);
      end
      send_byte(p[i]);
    end
    checks++;
    if (bus.pkt_done !== 1'b1) begin
      errors++;
      $display("FAIL pkt_done got=%b want=1 hdr=%h", bus.pkt_done, p[0]);
    end
    checks++;
    if (bus.error !== exp_err) begin
      errors++;
      $display("FAIL error_at_parity got=%b want=%b hdr=%h", bus.error, exp_err, p[0]);
    end
  endtask

  task automatic test_reset();
    bus.pkt_valid = 1'b0;
    bus.data_in   = 8'h00;
    bus.fifo_full = 3'b000;
    resetn = 1'b0;
    #12;
    checks += 5;
    if (bus.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    if (bus.error !== 1'b0)    begin errors++; $display("FAIL reset_error got=%b want=0", bus.error); end
    if (bus.pkt_done !== 1'b0) begin errors++; $display("FAIL reset_pkt_done got=%b want=0", bus.pkt_done); end
    if (bus.wr_en !== 3'b000)  begin errors++; $display("FAIL reset_wr_en got=%b want=000", bus.wr_en); end
    if (bus.wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got=%h want=00", bus.wr_data); end
    @(posedge clock); #1;
    resetn = 1'b1;
    idle(2);
  endtask

  task automatic test_good_packet();
    logic [7:0] p[$];
    int d0;
    p = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    obs.delete(); acc_q.delete();
    d0 = done_cnt;
    send_pkt(p, 0, 1'b0);
    idle(3);
    checks++;
    if (obs.size() != 5) begin errors++; $display("FAIL good_count got=%0d want=5", obs.size()); end
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      checks++;
      if (obs[i].port != 1 || obs[i].data !== p[i] || obs[i].edge_n != acc_q[i] + 1) begin
        errors++;
        $display("FAIL good_write%0d got port=%0d data=%h edge=%0d want port=1 data=%h edge=%0d",
                 i, obs[i].port, obs[i].data, obs[i].edge_n, p[i], acc_q[i] + 1);
      end
    end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL good_done_pulses got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_bad_parity();
    logic [7:0] p[$];
    p = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0E};
    obs.delete();
    send_pkt(p, 1, model_err(p));
    idle(4);
    checks++;
    if (bus.error !== 1'b1) begin errors++; $display("FAIL bad_error_hold got=%b want=1", bus.error); end
    checks++;
    if (obs.size() != 5) begin errors++; $display("FAIL bad_count got=%0d want=5", obs.size()); end
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      checks++;
      if (obs[i].port != 1 || obs[i].data !== p[i]) begin
        errors++;
        $display("FAIL bad_write%0d got port=%0d data=%h want port=1 data=%h", i, obs[i].port, obs[i].data, p[i]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] p[$];
    bus.fifo_full = 3'b000;
    send_byte(8'h0D);
    checks++;
    if (bus.error !== 1'b0) begin errors++; $display("FAIL header_clears_error got=%b want=0", bus.error); end
    send_byte(8'h11);
    bus.pkt_valid = 1'b0;
    bus.fifo_full = 3'b010;
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before_reset got=%b want=1", bus.busy); end
    resetn = 1'b0;
    #1;
    checks += 4;
    if (bus.busy !== 1'b0)     begin errors++; $display("FAIL mid_reset_busy got=%b want=0", bus.busy); end
    if (bus.wr_en !== 3'b000)  begin errors++; $display("FAIL mid_reset_wr_en got=%b want=000", bus.wr_en); end
    if (bus.wr_data !== 8'h00) begin errors++; $display("FAIL mid_reset_wr_data got=%h want=00", bus.wr_data); end
    if (bus.error !== 1'b0)    begin errors++; $display("FAIL mid_reset_error got=%b want=0", bus.error); end
    @(posedge clock); #1;
    resetn = 1'b1;
    bus.fifo_full = 3'b000;
    obs.delete();
    idle(2);
    p = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    send_pkt(p, 0, 1'b0);
    idle(3);
    checks++;
    if (obs.size() != 5) begin errors++; $display("FAIL after_reset_count got=%0d want=5", obs.size()); end
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      checks++;
      if (obs[i].port != 1 || obs[i].data !== p[i]) begin
        errors++;
        $display("FAIL after_reset_write%0d got port=%0d data=%h want port=1 data=%h", i, obs[i].port, obs[i].data, p[i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [7:0] p[$];
    p = '{8'h04, 8'hAA, 8'hAE};
    obs.delete();
    send_byte(p[0]);
    send_byte(p[1]);
    bus.fifo_full = 3'b001;
    bus.data_in   = p[2];
    repeat (3) begin
      @(negedge clock);
      checks += 2;
      if (bus.busy !== 1'b1)    begin errors++; $display("FAIL bp_busy got=%b want=1", bus.busy); end
      if (bus.wr_en !== 3'b000) begin errors++; $display("FAIL bp_wr_en got=%b want=000", bus.wr_en); end
      @(posedge clock); #1;
    end
    bus.fifo_full = 3'b000;
    send_byte(p[2]);
    checks++;
    if (bus.pkt_done !== 1'b1 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL bp_done got done=%b error=%b want done=1 error=0", bus.pkt_done, bus.error);
    end
    idle(3);
    checks++;
    if (obs.size() != 3) begin errors++; $display("FAIL bp_count got=%0d want=3", obs.size()); end
    for (int i = 0; i < 3 && i < obs.size(); i++) begin
      checks++;
      if (obs[i].port != 0 || obs[i].data !== p[i]) begin
        errors++;
        $display("FAIL bp_write%0d got port=%0d data=%h want port=0 data=%h", i, obs[i].port, obs[i].data, p[i]);
      end
    end
  endtask

  task automatic test_invalid_port();
    logic [7:0] p[$];
    int b0;
    p = '{8'h07, 8'h5A, 8'h5D};
    obs.delete();
    bus.fifo_full = 3'b111;
    b0 = busy_cnt;
    send_pkt(p, 0, 1'b1);
    idle(3);
    bus.fifo_full = 3'b000;
    checks += 2;
    if (obs.size() != 0) begin errors++; $display("FAIL inv_writes got=%0d want=0", obs.size()); end
    if (busy_cnt != b0)  begin errors++; $display("FAIL inv_busy_cycles got=%0d want=0", busy_cnt - b0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a[$];
    logic [7:0] b[$];
    logic [7:0] all[$];
    a = '{8'h02, 8'h02};
    b = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    all = {a, b};
    obs.delete();
    send_pkt(a, 0, 1'b0);
    send_pkt(b, 0, 1'b0);
    idle(3);
    checks++;
    if (obs.size() != 7) begin errors++; $display("FAIL b2b_count got=%0d want=7", obs.size()); end
    for (int i = 0; i < 7 && i < obs.size(); i++) begin
      int wp = (i < 2) ? 2 : 1;
      checks++;
      if (obs[i].port != wp || obs[i].data !== all[i] || obs[i].edge_n != obs[0].edge_n + i) begin
        errors++;
        $display("FAIL b2b_write%0d got port=%0d data=%h edge=%0d want port=%0d data=%h edge=%0d",
                 i, obs[i].port, obs[i].data, obs[i].edge_n, wp, all[i], obs[0].edge_n + i);
      end
    end
  endtask

  task automatic test_random();
    wr_t exp_q[$];
    obs.delete();
    rand_full = 1'b1;
    for (int n = 0; n < 30; n++) begin
      logic [7:0] p[$];
      logic [7:0] x;
      int len = $urandom_range(0, 6);
      logic [1:0] d = 2'($urandom_range(0, 3));
      p.push_back({6'(len), d});
      x = p[0];
      for (int k = 0; k < len; k++) begin
        p.push_back(8'($urandom));
        x ^= p[k+1];
      end
      p.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'h01) : x);
      if (d != 2'd3) begin
        foreach (p[k]) begin
          wr_t w;
          w.port = int'(d);
          w.data = p[k];
          w.edge_n = 0;
          exp_q.push_back(w);
        end
      end
      send_pkt(p, 2, model_err(p));
    end
    rand_full = 1'b0;
    bus.fifo_full = 3'b000;
    idle(6);
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count got=%0d want=%0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i].port != exp_q[i].port || obs[i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL rand_write%0d got port=%0d data=%h want port=%0d data=%h",
                 i, obs[i].port, obs[i].data, exp_q[i].port, exp_q[i].data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_reset_mid_packet();
    test_back_pressure();
    test_invalid_port();
    test_back_to_back();
    test_random();
    checks++;
    if (bad_onehot != 0) begin errors++; $display("FAIL wr_en_onehot got=%0d bad cycles want=0", bad_onehot); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1);
  end

endmodule
